fib_seq_ctrl: RTL and testbench

Sequencer for the Fibonacci down-counter datapath of the calculator. It accepts a request for F(n) through a start/ready handshake. It loads the external 9-bit down-counter once, then steps its own two-register Fibonacci accumulator once per counter decrement. When the counter reaches 1 it publishes the result with a one-cycle done pulse and a sticky overflow flag.

---
 rtl/fib_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_fib_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: loads the external down-counter once, then steps a two-register
// accumulator per decrement and publishes F(n) mod 2^D_W with a done pulse and sticky overflow.
module fib_seq_ctrl #(
   parameter int unsigned N_W = 9,
   parameter int unsigned D_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] n,
   input  logic           clr,
   output logic           ready,
   output logic           busy,
   output logic           cnt_w,
   output logic [N_W-1:0] cnt_val,
   input  logic [N_W-1:0] cnt_out,
   output logic [D_W-1:0] result,
   output logic           ovf,
   output logic           done
);

   localparam int unsigned S_W = D_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [D_W-1:0] a_q, a_d;
   logic [D_W-1:0] b_q, b_d;
   logic           ovf_int_q, ovf_int_d;
   logic [D_W-1:0] result_q, result_d;
   logic           ovf_q, ovf_d;
   logic           done_q, done_d;
   logic           cnt_w_q, cnt_w_d;
   logic [N_W-1:0] cnt_val_q, cnt_val_d;
   logic [S_W-1:0] sum;

   // Carry out of D_W bits is the overflow indication for one step
   assign sum = S_W'(a_q) + S_W'(b_q);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      ovf_int_d = ovf_int_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      cnt_val_d = cnt_val_q;
      done_d    = 1'b0;
      cnt_w_d   = 1'b0;
      if (clr) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (n == N_W'(0)) begin
                     result_d = '0;
                     ovf_d    = 1'b0;
                     done_d   = 1'b1;
                     state_d  = S_DONE;
                  end else if (n == N_W'(1)) begin
                     result_d = D_W'(1);
                     ovf_d    = 1'b0;
                     done_d   = 1'b1;
                     state_d  = S_DONE;
                  end else begin
                     a_d       = '0;
                     b_d       = D_W'(1);
                     ovf_int_d = 1'b0;
                     cnt_val_d = n - N_W'(1);
                     cnt_w_d   = 1'b1;
                     state_d   = S_LOAD;
                  end
               end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
               if (cnt_out == N_W'(0)) begin
                  // Counter misbehaved: publish what we have without stepping
                  result_d = b_q;
                  ovf_d    = ovf_int_q;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  a_d       = b_q;
                  b_d       = sum[D_W-1:0];
                  ovf_int_d = ovf_int_q | sum[D_W];
                  if (cnt_out == N_W'(1)) begin
                     result_d = sum[D_W-1:0];
                     ovf_d    = ovf_int_q | sum[D_W];
                     done_d   = 1'b1;
                     state_d  = S_DONE;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         ovf_int_q <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         cnt_w_q   <= 1'b0;
         cnt_val_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         ovf_int_q <= ovf_int_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         cnt_w_q   <= cnt_w_d;
         cnt_val_q <= cnt_val_d;
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign busy    = (state_q == S_LOAD) || (state_q == S_RUN);
   assign cnt_w   = cnt_w_q;
   assign cnt_val = cnt_val_q;
   assign result  = result_q;
   assign ovf     = ovf_q;
   assign done    = done_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: vector table, hand-written corner sequences and
// random requests, all checked against a Fibonacci reference and an external down-counter model.
module tb_fib_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  n;
   logic        clr;
   logic        ready, busy, cnt_w, ovf, done;
   logic [8:0]  cnt_val;
   logic [8:0]  cnt_out;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;
   logic [15:0] last_res;

   fib_seq_ctrl #(.N_W(9), .D_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .n(n), .clr(clr),
      .ready(ready), .busy(busy), .cnt_w(cnt_w), .cnt_val(cnt_val),
      .cnt_out(cnt_out), .result(result), .ovf(ovf), .done(done)
   );

   always #5 clk = ~clk;

   // External down-counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            cnt_out <= '0;
      else if (cnt_w)      cnt_out <= cnt_val;
      else if (cnt_out != 0) cnt_out <= cnt_out - 9'd1;
   end

   function automatic logic [15:0] fib_ref(input int k);
      int a = 0;
      int b = 1;
      int t;
      if (k == 0) return 16'd0;
      for (int i = 1; i < k; i++) begin
         t = (a + b) % 65536;
         a = b;
         b = t;
      end
      return 16'(b);
   endfunction

   // F(25)=75025 is the first value that does not fit in 16 bits
   function automatic logic ovf_ref(input int k);
      return k >= 25;
   endfunction

   function automatic int lat_ref(input int k);
      return (k >= 2) ? k + 1 : 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // Issue one request; poke pulses start mid-RUN and again during DONE
   task automatic run_req(input int nn, input bit poke);
      int lat, cw_n, cw_k, busy_err;
      logic [8:0] cw_v;
      @(negedge clk);
      start = 1'b1;
      n     = 9'(nn);
      chk("ready_before_start", 32'(ready), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; cw_n = 0; cw_k = -1; cw_v = '0; busy_err = 0;
      for (int k = 1; k <= 700; k++) begin
         if (cnt_w) begin
            cw_n++;
            cw_k = k;
            cw_v = cnt_val;
         end
         if (busy !== ((nn >= 2) && (k <= nn))) busy_err++;
         if (done) begin
            lat = k;
            break;
         end
         start = poke && (k == 4);
         if (start) n = 9'd0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk($sformatf("latency_n%0d", nn), 32'(lat), 32'(lat_ref(nn)));
      chk($sformatf("result_n%0d", nn), 32'(result), 32'(fib_ref(nn)));
      chk($sformatf("ovf_n%0d", nn), 32'(ovf), 32'(ovf_ref(nn)));
      chk($sformatf("busy_n%0d", nn), 32'(busy_err), 32'd0);
      chk($sformatf("cnt_w_count_n%0d", nn), 32'(cw_n), (nn >= 2) ? 32'd1 : 32'd0);
      if (nn >= 2) begin
         chk($sformatf("cnt_w_cycle_n%0d", nn), 32'(cw_k), 32'd1);
         chk($sformatf("cnt_val_n%0d", nn), 32'(cw_v), 32'(nn - 1));
      end
      last_res = fib_ref(nn);
      start = poke;
      n     = 9'd1;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("idle_after_done_n%0d", nn), 32'({ready, busy, done}), 32'b100);
   endtask

   typedef struct {
      int         nn;
      logic [15:0] exp_res;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   vec_t vecs[8];
   int   done_seen;

   initial begin
      vecs[0] = '{0,  16'd0,     1'b0, 1};
      vecs[1] = '{1,  16'd1,     1'b0, 1};
      vecs[2] = '{10, 16'd55,    1'b0, 11};
      vecs[3] = '{24, 16'd46368, 1'b0, 25};
      vecs[4] = '{25, 16'd9489,  1'b1, 26};
      vecs[5] = '{5,  16'd5,     1'b0, 6};
      vecs[6] = '{2,  16'd1,     1'b0, 3};
      vecs[7] = '{3,  16'd2,     1'b0, 4};

      rst = 1'b0; start = 1'b0; n = '0; clr = 1'b0; last_res = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({ready, busy, cnt_w, ovf, done}), 32'b10000);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_cnt_val", 32'(cnt_val), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Vector table: reference table must agree with the model, then with the DUT
      foreach (vecs[i]) begin
         chk($sformatf("table_ref_n%0d", vecs[i].nn),
             32'({fib_ref(vecs[i].nn), ovf_ref(vecs[i].nn)}),
             32'({vecs[i].exp_res, vecs[i].exp_ovf}));
         chk($sformatf("table_lat_n%0d", vecs[i].nn), 32'(lat_ref(vecs[i].nn)), 32'(vecs[i].exp_lat));
         run_req(vecs[i].nn, 1'b0);
      end

      // start pulsed in RUN and in DONE must be ignored
      run_req(10, 1'b1);
      run_req(4, 1'b0);

      // clr mid-RUN: back to IDLE, no done, result untouched
      @(negedge clk);
      start = 1'b1; n = 9'd20;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk("busy_before_clr", 32'(busy), 32'd1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("clr_idle", 32'({ready, busy, cnt_w, done}), 32'b1000);
      chk("clr_result_kept", 32'(result), 32'(last_res));
      done_seen = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      chk("clr_no_done", 32'(done_seen), 32'd0);
      run_req(7, 1'b0);

      // async reset mid-RUN
      @(negedge clk);
      start = 1'b1; n = 9'd15;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'({ready, busy, cnt_w, ovf, done}), 32'b10000);
      chk("rst_mid_result", 32'(result), 32'd0);
      chk("rst_mid_cnt_val", 32'(cnt_val), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_req(3, 1'b0);

      // Random requests, occasionally with ignored start pokes
      for (int r = 0; r < 20; r++) begin
         int nn;
         nn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 30));
         run_req(nn, ($urandom_range(0, 4) == 0) && (nn >= 5));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
